// File: rtl/equiv_sweep_checker.sv
// Exhaustive equivalence sweep of two combinational units.
// Drives every input vector, compares m_q and m_a, reports a verdict.
module equiv_sweep_checker #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            m_q,
    input  logic            m_a,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            aborted,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0]      LP_SET_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LP_VEC_LAST = {N_IN{1'b1}};

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic [3:0]      r_cnt;
    logic [N_IN:0]   r_err;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_valid;
    logic            r_pass;
    logic            r_aborted;

    state_t          w_state_nx;
    logic [N_IN-1:0] w_vec_nx;
    logic [3:0]      w_cnt_nx;
    logic [N_IN:0]   w_err_nx;
    logic [N_IN-1:0] w_fail_vec_nx;
    logic            w_fail_valid_nx;
    logic            w_pass_nx;
    logic            w_aborted_nx;
    logic            w_mis;

    // State and sweep bookkeeping registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_vec        <= w_vec_nx;
            r_cnt        <= w_cnt_nx;
            r_err        <= w_err_nx;
            r_fail_vec   <= w_fail_vec_nx;
            r_fail_valid <= w_fail_valid_nx;
            r_pass       <= w_pass_nx;
            r_aborted    <= w_aborted_nx;
        end
    end

    // Next-state, vector stepping and mismatch accumulation
    always_comb begin
        w_state_nx      = r_state;
        w_vec_nx        = r_vec;
        w_cnt_nx        = r_cnt;
        w_err_nx        = r_err;
        w_fail_vec_nx   = r_fail_vec;
        w_fail_valid_nx = r_fail_valid;
        w_pass_nx       = r_pass;
        w_aborted_nx    = r_aborted;
        w_mis           = (r_state == S_COMPARE) && (m_q != m_a);

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx      = S_DRIVE;
                    w_vec_nx        = '0;
                    w_cnt_nx        = '0;
                    w_err_nx        = '0;
                    w_fail_valid_nx = 1'b0;
                    w_pass_nx       = 1'b0;
                    w_aborted_nx    = 1'b0;
                end
            end
            S_DRIVE: begin
                w_cnt_nx = r_cnt + 4'd1;
                if (abort) begin
                    w_state_nx   = S_DONE;
                    w_aborted_nx = 1'b1;
                    w_pass_nx    = 1'b0;
                end else if (r_cnt == LP_SET_LAST) begin
                    w_state_nx = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_mis) begin
                    w_err_nx = r_err + (N_IN+1)'(1);
                    if (!r_fail_valid) begin
                        w_fail_vec_nx   = r_vec;
                        w_fail_valid_nx = 1'b1;
                    end
                end
                if (abort) begin
                    w_state_nx   = S_DONE;
                    w_aborted_nx = 1'b1;
                    w_pass_nx    = 1'b0;
                end else if (r_vec == LP_VEC_LAST) begin
                    w_state_nx = S_DONE;
                    w_pass_nx  = (w_err_nx == '0);
                end else begin
                    w_state_nx = S_DRIVE;
                    w_vec_nx   = r_vec + N_IN'(1);
                    w_cnt_nx   = '0;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign vec        = r_vec;
    assign busy       = (r_state == S_DRIVE) || (r_state == S_COMPARE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign aborted    = r_aborted;
    assign err_cnt    = r_err;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
